// File: rtl/ibex_pkg.sv
// Types shared between the ID/EX stage and the in-order writeback queue.
// Entries keep a 64-bit FP payload so a single struct serves both FP widths.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  localparam int unsigned WbFpDataW = 64;

  typedef struct packed {
    wb_instr_type_e       instr_type;
    logic [31:0]          pc;
    logic                 perf_count;
    logic                 compressed;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic                 fp_we;
    logic [4:0]           fp_waddr;
    logic [WbFpDataW-1:0] fp_wdata;
    logic                 fp_load;
  } wb_entry_t;

  function automatic logic [31:0] wb_reg_onehot(input logic [4:0] addr);
    logic [31:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

  function automatic int unsigned wb_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ibex_wb_queue_ptr.sv
// Wrap-around queue pointer: counts 0..Depth-1 and returns to 0, including
// for depths that are not a power of two.
module ibex_wb_queue_ptr #(
  parameter int unsigned Depth = 2,
  parameter int unsigned PtrW  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            clear_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ibex_wb_queue.sv
// In-order writeback queue: buffers issued instructions, retires them from
// the head in program order and drives the integer/FP register-file writes.
module ibex_wb_queue
  import ibex_pkg::*;
#(
  parameter int unsigned Depth     = 2,
  parameter bit          FpEn      = 1'b1,
  parameter int unsigned FPU_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,

  input  logic                         en_wb_i,
  input  wb_instr_type_e               instr_type_wb_i,
  input  logic [31:0]                  pc_id_i,
  input  logic                         instr_perf_count_id_i,
  input  logic                         instr_is_compressed_id_i,
  input  logic                         rf_we_id_i,
  input  logic [4:0]                   rf_waddr_id_i,
  input  logic [31:0]                  rf_wdata_id_i,
  input  logic                         fp_rf_we_id_i,
  input  logic [4:0]                   fp_rf_waddr_id_i,
  input  logic [FPU_WIDTH-1:0]         fp_rf_wdata_id_i,
  input  logic                         fp_load_id_i,

  input  logic                         lsu_resp_valid_i,
  input  logic                         lsu_resp_err_i,
  input  logic                         rf_we_lsu_i,
  input  logic [31:0]                  rf_wdata_lsu_i,

  output logic                         ready_wb_o,
  output logic                         rf_we_wb_o,
  output logic [4:0]                   rf_waddr_wb_o,
  output logic [31:0]                  rf_wdata_wb_o,
  output logic                         fp_rf_we_wb_o,
  output logic [4:0]                   fp_rf_waddr_wb_o,
  output logic [FPU_WIDTH-1:0]         fp_rf_wdata_wb_o,
  output logic [31:0]                  rf_pending_o,
  output logic [31:0]                  fp_rf_pending_o,
  output logic                         outstanding_load_wb_o,
  output logic                         outstanding_store_wb_o,
  output logic                         instr_done_wb_o,
  output logic [31:0]                  pc_wb_o,
  output logic                         perf_instr_ret_wb_o,
  output logic                         perf_instr_ret_compressed_wb_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o
);

  localparam int unsigned PtrW = wb_ptr_width(Depth);
  localparam int unsigned OccW = $clog2(Depth + 1);

  wb_entry_t        entry_q [Depth];
  wb_entry_t        entry_d [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [OccW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  rd_ptr, wr_ptr;

  wb_entry_t        head, new_entry;
  logic             head_valid, head_is_load, head_is_lsu;
  logic             lsu_err, head_done, full, push;
  logic             rf_we_from_id, rf_we_from_lsu;

  logic                 fp_we_in, fp_load_in;
  logic [4:0]           fp_waddr_in;
  logic [WbFpDataW-1:0] fp_wdata_in;
  logic [FPU_WIDTH-1:0] fp_load_data;

  ibex_wb_queue_ptr #(.Depth(Depth), .PtrW(PtrW)) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (head_done),
    .clear_i (1'b0),
    .ptr_o   (rd_ptr)
  );

  ibex_wb_queue_ptr #(.Depth(Depth), .PtrW(PtrW)) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (push),
    .clear_i (1'b0),
    .ptr_o   (wr_ptr)
  );

  // FP fields are constant zero without an FP RF, so their flops drop out.
  if (FpEn) begin : g_fp_in
    assign fp_we_in    = fp_rf_we_id_i;
    assign fp_load_in  = fp_load_id_i;
    assign fp_waddr_in = fp_rf_waddr_id_i;
    assign fp_wdata_in = WbFpDataW'(fp_rf_wdata_id_i);
  end else begin : g_no_fp_in
    assign fp_we_in    = 1'b0;
    assign fp_load_in  = 1'b0;
    assign fp_waddr_in = '0;
    assign fp_wdata_in = '0;
  end

  // Single-precision load data is NaN-boxed on a 64-bit FP RF.
  if (FPU_WIDTH == 64) begin : g_nan_box
    assign fp_load_data = {32'hFFFF_FFFF, rf_wdata_lsu_i};
  end else begin : g_no_nan_box
    assign fp_load_data = rf_wdata_lsu_i;
  end

  always_comb begin
    head         = entry_q[rd_ptr];
    head_valid   = valid_q[rd_ptr];
    head_is_load = (head.instr_type == WB_INSTR_LOAD);
    head_is_lsu  = (head.instr_type != WB_INSTR_OTHER);
    lsu_err      = lsu_resp_valid_i & lsu_resp_err_i;
    head_done    = head_valid & (~head_is_lsu | lsu_resp_valid_i);
    full         = (cnt_q == OccW'(Depth));
    push         = en_wb_i & (~full | head_done);
  end

  always_comb begin
    new_entry            = '0;
    new_entry.instr_type = instr_type_wb_i;
    new_entry.pc         = pc_id_i;
    new_entry.perf_count = instr_perf_count_id_i;
    new_entry.compressed = instr_is_compressed_id_i;
    new_entry.rf_we      = rf_we_id_i;
    new_entry.rf_waddr   = rf_waddr_id_i;
    new_entry.rf_wdata   = rf_wdata_id_i;
    new_entry.fp_we      = fp_we_in;
    new_entry.fp_waddr   = fp_waddr_in;
    new_entry.fp_wdata   = fp_wdata_in;
    new_entry.fp_load    = fp_load_in;
  end

  // Pop before push so a full queue can retire and accept in the same cycle.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (head_done) begin
      valid_d[rd_ptr] = 1'b0;
    end
    if (push) begin
      valid_d[wr_ptr] = 1'b1;
      entry_d[wr_ptr] = new_entry;
    end
    cnt_d = cnt_q + OccW'(push) - OccW'(head_done);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    rf_we_from_id  = head_done & head.rf_we & ~lsu_err;
    rf_we_from_lsu = head_done & head_is_load & rf_we_lsu_i & ~head.fp_load & ~lsu_err;

    ready_wb_o    = ~full | head_done;
    rf_we_wb_o    = (rf_we_from_id | rf_we_from_lsu) & (head.rf_waddr != 5'd0);
    rf_waddr_wb_o = head_done ? head.rf_waddr : '0;
    rf_wdata_wb_o = '0;
    if (head_done) begin
      rf_wdata_wb_o = head_is_load ? rf_wdata_lsu_i : head.rf_wdata;
    end

    fp_rf_we_wb_o    = 1'b0;
    fp_rf_waddr_wb_o = '0;
    fp_rf_wdata_wb_o = '0;
    if (FpEn && head_done) begin
      fp_rf_we_wb_o    = ~lsu_err & (head.fp_we | (head_is_load & rf_we_lsu_i & head.fp_load));
      fp_rf_waddr_wb_o = head.fp_waddr;
      fp_rf_wdata_wb_o = (head_is_load && head.fp_load) ? fp_load_data
                                                        : head.fp_wdata[FPU_WIDTH-1:0];
    end

    instr_done_wb_o                = head_done;
    pc_wb_o                        = head_valid ? head.pc : '0;
    perf_instr_ret_wb_o            = head_done & head.perf_count & ~lsu_err;
    perf_instr_ret_compressed_wb_o = head_done & head.perf_count & head.compressed & ~lsu_err;
    occupancy_o                    = cnt_q;
  end

  // The retiring head no longer blocks ID, its write lands this cycle.
  always_comb begin
    rf_pending_o           = '0;
    fp_rf_pending_o        = '0;
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i]) begin
        outstanding_load_wb_o  |= (entry_q[i].instr_type == WB_INSTR_LOAD);
        outstanding_store_wb_o |= (entry_q[i].instr_type == WB_INSTR_STORE);
        if (!(head_done && (rd_ptr == PtrW'(i)))) begin
          if (entry_q[i].rf_we ||
              ((entry_q[i].instr_type == WB_INSTR_LOAD) && !entry_q[i].fp_load)) begin
            rf_pending_o |= wb_reg_onehot(entry_q[i].rf_waddr);
          end
          if (entry_q[i].fp_we ||
              ((entry_q[i].instr_type == WB_INSTR_LOAD) && entry_q[i].fp_load)) begin
            fp_rf_pending_o |= wb_reg_onehot(entry_q[i].fp_waddr);
          end
        end
      end
    end
    rf_pending_o[0] = 1'b0;
    if (!FpEn) begin
      fp_rf_pending_o = '0;
    end
  end

  a_rf_we_source_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({rf_we_from_id, rf_we_from_lsu}));

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (en_wb_i && full) |-> head_done);

  a_lsu_resp_to_lsu_head : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> (head_valid && head_is_lsu));

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Self-checking bench for the writeback queue: a Depth=2 FP64 instance and a
// Depth=3 integer-only instance, with a scoreboard of expected RF writes.
module tb_ibex_wb_queue;
  import ibex_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           en, en3;
  wb_instr_type_e itype;
  logic [31:0]    pc;
  logic           perf_cnt, compr;
  logic           rf_we;
  logic [4:0]     rf_waddr;
  logic [31:0]    rf_wdata;
  logic           fp_we;
  logic [4:0]     fp_waddr;
  logic [63:0]    fp_wdata;
  logic           fp_load;
  logic           lsu_v, lsu_err, lsu_we;
  logic [31:0]    lsu_data;

  logic        d2_ready, d2_rf_we, d2_fp_we, d2_out_ld, d2_out_st, d2_done, d2_perf, d2_perf_c;
  logic [4:0]  d2_rf_waddr, d2_fp_waddr;
  logic [31:0] d2_rf_wdata, d2_rf_pend, d2_fp_pend, d2_pc;
  logic [63:0] d2_fp_wdata;
  logic [1:0]  d2_occ;

  logic        d3_ready, d3_rf_we, d3_fp_we, d3_out_ld, d3_out_st, d3_done, d3_perf, d3_perf_c;
  logic [4:0]  d3_rf_waddr, d3_fp_waddr;
  logic [31:0] d3_rf_wdata, d3_rf_pend, d3_fp_pend, d3_pc;
  logic [31:0] d3_fp_wdata;
  logic [1:0]  d3_occ;

  ibex_wb_queue #(.Depth(2), .FpEn(1'b1), .FPU_WIDTH(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .en_wb_i(en), .instr_type_wb_i(itype), .pc_id_i(pc),
    .instr_perf_count_id_i(perf_cnt), .instr_is_compressed_id_i(compr),
    .rf_we_id_i(rf_we), .rf_waddr_id_i(rf_waddr), .rf_wdata_id_i(rf_wdata),
    .fp_rf_we_id_i(fp_we), .fp_rf_waddr_id_i(fp_waddr), .fp_rf_wdata_id_i(fp_wdata),
    .fp_load_id_i(fp_load),
    .lsu_resp_valid_i(lsu_v), .lsu_resp_err_i(lsu_err), .rf_we_lsu_i(lsu_we),
    .rf_wdata_lsu_i(lsu_data),
    .ready_wb_o(d2_ready), .rf_we_wb_o(d2_rf_we), .rf_waddr_wb_o(d2_rf_waddr),
    .rf_wdata_wb_o(d2_rf_wdata), .fp_rf_we_wb_o(d2_fp_we), .fp_rf_waddr_wb_o(d2_fp_waddr),
    .fp_rf_wdata_wb_o(d2_fp_wdata), .rf_pending_o(d2_rf_pend), .fp_rf_pending_o(d2_fp_pend),
    .outstanding_load_wb_o(d2_out_ld), .outstanding_store_wb_o(d2_out_st),
    .instr_done_wb_o(d2_done), .pc_wb_o(d2_pc), .perf_instr_ret_wb_o(d2_perf),
    .perf_instr_ret_compressed_wb_o(d2_perf_c), .occupancy_o(d2_occ)
  );

  ibex_wb_queue #(.Depth(3), .FpEn(1'b0), .FPU_WIDTH(32)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .en_wb_i(en3), .instr_type_wb_i(itype), .pc_id_i(pc),
    .instr_perf_count_id_i(perf_cnt), .instr_is_compressed_id_i(compr),
    .rf_we_id_i(rf_we), .rf_waddr_id_i(rf_waddr), .rf_wdata_id_i(rf_wdata),
    .fp_rf_we_id_i(fp_we), .fp_rf_waddr_id_i(fp_waddr), .fp_rf_wdata_id_i(fp_wdata[31:0]),
    .fp_load_id_i(fp_load),
    .lsu_resp_valid_i(1'b0), .lsu_resp_err_i(1'b0), .rf_we_lsu_i(1'b0),
    .rf_wdata_lsu_i(32'h0),
    .ready_wb_o(d3_ready), .rf_we_wb_o(d3_rf_we), .rf_waddr_wb_o(d3_rf_waddr),
    .rf_wdata_wb_o(d3_rf_wdata), .fp_rf_we_wb_o(d3_fp_we), .fp_rf_waddr_wb_o(d3_fp_waddr),
    .fp_rf_wdata_wb_o(d3_fp_wdata), .rf_pending_o(d3_rf_pend), .fp_rf_pending_o(d3_fp_pend),
    .outstanding_load_wb_o(d3_out_ld), .outstanding_store_wb_o(d3_out_st),
    .instr_done_wb_o(d3_done), .pc_wb_o(d3_pc), .perf_instr_ret_wb_o(d3_perf),
    .perf_instr_ret_compressed_wb_o(d3_perf_c), .occupancy_o(d3_occ)
  );

  typedef struct {
    logic        fp;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; en3 = 1'b0; itype = WB_INSTR_OTHER; pc = '0;
    perf_cnt = 1'b0; compr = 1'b0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    fp_we = 1'b0; fp_waddr = '0; fp_wdata = '0; fp_load = 1'b0;
    lsu_v = 1'b0; lsu_err = 1'b0; lsu_we = 1'b0; lsu_data = '0;
  endtask

  task automatic drive(input wb_instr_type_e t, input logic [31:0] p, input logic we,
                       input logic [4:0] a, input logic [31:0] d, input logic fwe,
                       input logic [4:0] fa, input logic [63:0] fd, input logic fl,
                       input logic cnt, input logic cmp);
    en = 1'b1; itype = t; pc = p; rf_we = we; rf_waddr = a; rf_wdata = d;
    fp_we = fwe; fp_waddr = fa; fp_wdata = fd; fp_load = fl; perf_cnt = cnt; compr = cmp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (d2_occ !== 2'd0 || d2_ready !== 1'b1) begin errors++;
      $display("FAIL reset_occ_ready: got occ=%0d ready=%0b want occ=0 ready=1", d2_occ, d2_ready); end
    checks++; if ({d2_done, d2_rf_we, d2_fp_we, d2_out_ld, d2_out_st, d2_perf, d2_perf_c} !== 7'b0) begin errors++;
      $display("FAIL reset_strobes: got %b want 0000000",
               {d2_done, d2_rf_we, d2_fp_we, d2_out_ld, d2_out_st, d2_perf, d2_perf_c}); end
    checks++; if (d2_rf_pend !== 32'h0 || d2_fp_pend !== 32'h0 || d2_pc !== 32'h0) begin errors++;
      $display("FAIL reset_masks_pc: got rp=%h fp=%h pc=%h want 0", d2_rf_pend, d2_fp_pend, d2_pc); end
    checks++; if (d3_occ !== 2'd0 || d3_ready !== 1'b1) begin errors++;
      $display("FAIL reset_d3: got occ=%0d ready=%0b want occ=0 ready=1", d3_occ, d3_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_other_latency();
    drive(WB_INSTR_OTHER, 32'h100, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b1);
    sb.push_back('{fp: 1'b0, addr: 5'd5, data: 64'h1234, pc: 32'h100});
    #1;
    checks++; if (d2_ready !== 1'b1 || d2_done !== 1'b0) begin errors++;
      $display("FAIL lat_push: got ready=%0b done=%0b want ready=1 done=0", d2_ready, d2_done); end
    tick();
    idle();
    #1;
    e = sb.pop_front();
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b1 || d2_rf_waddr !== e.addr ||
                  d2_rf_wdata !== e.data[31:0] || d2_pc !== e.pc) begin errors++;
      $display("FAIL lat_write: got done=%0b we=%0b a=%0d d=%h pc=%h want done=1 we=1 a=%0d d=%h pc=%h",
               d2_done, d2_rf_we, d2_rf_waddr, d2_rf_wdata, d2_pc, 1'b1, e.addr, e.data[31:0], e.pc); end
    checks++; if (d2_perf !== 1'b1 || d2_perf_c !== 1'b1 || d2_occ !== 2'd1 || d2_rf_pend !== 32'h0) begin errors++;
      $display("FAIL lat_perf: got perf=%0b perfc=%0b occ=%0d pend=%h want 1 1 1 0",
               d2_perf, d2_perf_c, d2_occ, d2_rf_pend); end
    tick();
    checks++; if (d2_occ !== 2'd0) begin errors++;
      $display("FAIL lat_drain: got occ=%0d want 0", d2_occ); end
  endtask

  task automatic test_load_order();
    drive(WB_INSTR_LOAD, 32'h200, 1'b0, 5'd6, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b0, addr: 5'd6, data: 64'hCAFE_0006, pc: 32'h200});
    tick();
    drive(WB_INSTR_OTHER, 32'h204, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b0, addr: 5'd7, data: 64'h77, pc: 32'h204});
    #1;
    checks++; if (d2_rf_pend !== 32'h40 || d2_ready !== 1'b1 || d2_done !== 1'b0) begin errors++;
      $display("FAIL ld_first: got pend=%h ready=%0b done=%0b want pend=00000040 ready=1 done=0",
               d2_rf_pend, d2_ready, d2_done); end
    tick();
    idle();
    #1;
    checks++; if (d2_rf_pend !== 32'hC0 || d2_ready !== 1'b0 || d2_occ !== 2'd2 ||
                  d2_out_ld !== 1'b1 || d2_done !== 1'b0) begin errors++;
      $display("FAIL ld_full: got pend=%h ready=%0b occ=%0d outld=%0b done=%0b want 000000c0 0 2 1 0",
               d2_rf_pend, d2_ready, d2_occ, d2_out_ld, d2_done); end
    tick();
    tick();
    lsu_v = 1'b1; lsu_we = 1'b1; lsu_data = 32'hCAFE_0006;
    #1;
    e = sb.pop_front();
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b1 || d2_rf_waddr !== e.addr ||
                  d2_rf_wdata !== e.data[31:0] || d2_pc !== e.pc) begin errors++;
      $display("FAIL ld_resp_write: got done=%0b we=%0b a=%0d d=%h pc=%h want 1 1 a=%0d d=%h pc=%h",
               d2_done, d2_rf_we, d2_rf_waddr, d2_rf_wdata, d2_pc, e.addr, e.data[31:0], e.pc); end
    checks++; if (d2_rf_pend !== 32'h80 || d2_ready !== 1'b1 || d2_perf_c !== 1'b0) begin errors++;
      $display("FAIL ld_resp_pend: got pend=%h ready=%0b perfc=%0b want 00000080 1 0",
               d2_rf_pend, d2_ready, d2_perf_c); end
    tick();
    idle();
    #1;
    e = sb.pop_front();
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b1 || d2_rf_waddr !== e.addr ||
                  d2_rf_wdata !== e.data[31:0] || d2_out_ld !== 1'b0) begin errors++;
      $display("FAIL ld_second_write: got done=%0b we=%0b a=%0d d=%h outld=%0b want 1 1 a=%0d d=%h outld=0",
               d2_done, d2_rf_we, d2_rf_waddr, d2_rf_wdata, d2_out_ld, e.addr, e.data[31:0]); end
    tick();
    checks++; if (d2_occ !== 2'd0) begin errors++;
      $display("FAIL ld_drain: got occ=%0d want 0", d2_occ); end
  endtask

  task automatic test_back_to_back();
    drive(WB_INSTR_LOAD, 32'h300, 1'b0, 5'd8, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b0, addr: 5'd8, data: 64'h8888_0008, pc: 32'h300});
    tick();
    drive(WB_INSTR_LOAD, 32'h304, 1'b0, 5'd9, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b0, addr: 5'd9, data: 64'h9999_0009, pc: 32'h304});
    tick();
    drive(WB_INSTR_OTHER, 32'h308, 1'b1, 5'd10, 32'hA0A0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b0, addr: 5'd10, data: 64'hA0A0, pc: 32'h308});
    lsu_v = 1'b1; lsu_we = 1'b1; lsu_data = 32'h8888_0008;
    #1;
    e = sb.pop_front();
    checks++; if (d2_ready !== 1'b1 || d2_occ !== 2'd2) begin errors++;
      $display("FAIL b2b_ready: got ready=%0b occ=%0d want ready=1 occ=2", d2_ready, d2_occ); end
    checks++; if (d2_done !== 1'b1 || d2_rf_waddr !== e.addr || d2_rf_wdata !== e.data[31:0]) begin errors++;
      $display("FAIL b2b_first: got done=%0b a=%0d d=%h want 1 a=%0d d=%h",
               d2_done, d2_rf_waddr, d2_rf_wdata, e.addr, e.data[31:0]); end
    tick();
    idle();
    lsu_v = 1'b1; lsu_we = 1'b1; lsu_data = 32'h9999_0009;
    #1;
    e = sb.pop_front();
    checks++; if (d2_occ !== 2'd2 || d2_done !== 1'b1 || d2_rf_waddr !== e.addr ||
                  d2_rf_wdata !== e.data[31:0]) begin errors++;
      $display("FAIL b2b_second: got occ=%0d done=%0b a=%0d d=%h want occ=2 done=1 a=%0d d=%h",
               d2_occ, d2_done, d2_rf_waddr, d2_rf_wdata, e.addr, e.data[31:0]); end
    tick();
    idle();
    #1;
    e = sb.pop_front();
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b1 || d2_rf_waddr !== e.addr ||
                  d2_rf_wdata !== e.data[31:0] || d2_pc !== e.pc) begin errors++;
      $display("FAIL b2b_pushed: got done=%0b we=%0b a=%0d d=%h pc=%h want 1 1 a=%0d d=%h pc=%h",
               d2_done, d2_rf_we, d2_rf_waddr, d2_rf_wdata, d2_pc, e.addr, e.data[31:0], e.pc); end
    tick();
    checks++; if (d2_occ !== 2'd0) begin errors++;
      $display("FAIL b2b_drain: got occ=%0d want 0", d2_occ); end
  endtask

  task automatic test_load_error();
    drive(WB_INSTR_STORE, 32'h400, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(WB_INSTR_LOAD, 32'h404, 1'b0, 5'd11, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (d2_out_ld !== 1'b1 || d2_out_st !== 1'b1) begin errors++;
      $display("FAIL err_outstanding: got ld=%0b st=%0b want 1 1", d2_out_ld, d2_out_st); end
    lsu_v = 1'b1;
    #1;
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b0 || d2_perf !== 1'b1 || d2_pc !== 32'h400) begin errors++;
      $display("FAIL err_store_retire: got done=%0b we=%0b perf=%0b pc=%h want 1 0 1 00000400",
               d2_done, d2_rf_we, d2_perf, d2_pc); end
    tick();
    lsu_v = 1'b1; lsu_err = 1'b1; lsu_we = 1'b0; lsu_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b0 || d2_perf !== 1'b0 ||
                  d2_pc !== 32'h404 || d2_out_st !== 1'b0) begin errors++;
      $display("FAIL err_load_retire: got done=%0b we=%0b perf=%0b pc=%h st=%0b want 1 0 0 00000404 0",
               d2_done, d2_rf_we, d2_perf, d2_pc, d2_out_st); end
    tick();
    idle();
    #1;
    checks++; if (d2_occ !== 2'd0 || d2_done !== 1'b0) begin errors++;
      $display("FAIL err_drain: got occ=%0d done=%0b want 0 0", d2_occ, d2_done); end
  endtask

  task automatic test_fp_load();
    drive(WB_INSTR_LOAD, 32'h500, 1'b0, 5'd3, 32'h0, 1'b0, 5'd3, 64'h0, 1'b1, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b1, addr: 5'd3, data: 64'hFFFF_FFFF_3F80_0000, pc: 32'h500});
    tick();
    drive(WB_INSTR_OTHER, 32'h504, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b1, addr: 5'd4, data: 64'h1122_3344_5566_7788, pc: 32'h504});
    #1;
    checks++; if (d2_fp_pend !== 32'h8 || d2_rf_pend !== 32'h0) begin errors++;
      $display("FAIL fp_pending: got fp=%h rf=%h want 00000008 00000000", d2_fp_pend, d2_rf_pend); end
    tick();
    idle();
    lsu_v = 1'b1; lsu_we = 1'b1; lsu_data = 32'h3F80_0000;
    #1;
    e = sb.pop_front();
    checks++; if (d2_done !== 1'b1 || d2_fp_we !== 1'b1 || d2_fp_waddr !== e.addr ||
                  d2_fp_wdata !== e.data || d2_rf_we !== 1'b0) begin errors++;
      $display("FAIL fp_load_write: got done=%0b fwe=%0b a=%0d d=%h we=%0b want 1 1 a=%0d d=%h we=0",
               d2_done, d2_fp_we, d2_fp_waddr, d2_fp_wdata, d2_rf_we, e.addr, e.data); end
    checks++; if (d2_fp_pend !== 32'h10) begin errors++;
      $display("FAIL fp_pending_after: got %h want 00000010", d2_fp_pend); end
    tick();
    idle();
    #1;
    e = sb.pop_front();
    checks++; if (d2_done !== 1'b1 || d2_fp_we !== 1'b1 || d2_fp_waddr !== e.addr ||
                  d2_fp_wdata !== e.data || d2_rf_we !== 1'b0) begin errors++;
      $display("FAIL fp_other_write: got done=%0b fwe=%0b a=%0d d=%h we=%0b want 1 1 a=%0d d=%h we=0",
               d2_done, d2_fp_we, d2_fp_waddr, d2_fp_wdata, d2_rf_we, e.addr, e.data); end
    tick();
  endtask

  task automatic test_x0();
    drive(WB_INSTR_LOAD, 32'h600, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (d2_rf_pend !== 32'h0 || d2_occ !== 2'd1) begin errors++;
      $display("FAIL x0_pending: got pend=%h occ=%0d want 00000000 1", d2_rf_pend, d2_occ); end
    lsu_v = 1'b1; lsu_we = 1'b1; lsu_data = 32'h5555_5555;
    #1;
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b0) begin errors++;
      $display("FAIL x0_write: got done=%0b we=%0b want done=1 we=0", d2_done, d2_rf_we); end
    tick();
    idle();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 7) begin
        en3 = 1'b1; itype = WB_INSTR_OTHER; rf_we = 1'b1; rf_waddr = 5'(i + 1);
        rf_wdata = 32'h3000 + 32'(i); pc = 32'h700 + 32'(4 * i);
        sb3.push_back('{fp: 1'b0, addr: 5'(i + 1), data: 64'(32'h3000 + 32'(i)), pc: 32'h700 + 32'(4 * i)});
      end
      #1;
      if (i == 0) begin
        checks++; if (d3_done !== 1'b0 || d3_occ !== 2'd0) begin errors++;
          $display("FAIL wrap_start: got done=%0b occ=%0d want 0 0", d3_done, d3_occ); end
      end else begin
        e = sb3.pop_front();
        checks++; if (d3_done !== 1'b1 || d3_rf_we !== 1'b1 || d3_rf_waddr !== e.addr ||
                      d3_rf_wdata !== e.data[31:0] || d3_pc !== e.pc || d3_occ !== 2'd1) begin errors++;
          $display("FAIL wrap_retire%0d: got done=%0b we=%0b a=%0d d=%h pc=%h occ=%0d want 1 1 a=%0d d=%h pc=%h occ=1",
                   i, d3_done, d3_rf_we, d3_rf_waddr, d3_rf_wdata, d3_pc, d3_occ,
                   e.addr, e.data[31:0], e.pc); end
      end
      tick();
    end
    idle();
    #1;
    checks++; if (d3_occ !== 2'd0 || sb3.size() != 0) begin errors++;
      $display("FAIL wrap_drain: got occ=%0d left=%0d want 0 0", d3_occ, sb3.size()); end
  endtask

  task automatic test_reset_mid();
    drive(WB_INSTR_LOAD, 32'h7F0, 1'b0, 5'd13, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    en3 = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (d2_out_ld !== 1'b1 || d3_out_ld !== 1'b1) begin errors++;
      $display("FAIL rstmid_pre: got ld2=%0b ld3=%0b want 1 1", d2_out_ld, d3_out_ld); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (d2_occ !== 2'd0 || d2_ready !== 1'b1 || d2_rf_pend !== 32'h0 || d2_out_ld !== 1'b0 ||
                  d2_done !== 1'b0 || d2_pc !== 32'h0 || d2_rf_we !== 1'b0) begin errors++;
      $display("FAIL rstmid_d2: got occ=%0d ready=%0b pend=%h ld=%0b done=%0b pc=%h we=%0b want 0 1 0 0 0 0 0",
               d2_occ, d2_ready, d2_rf_pend, d2_out_ld, d2_done, d2_pc, d2_rf_we); end
    checks++; if (d3_occ !== 2'd0 || d3_ready !== 1'b1 || d3_out_ld !== 1'b0 || d3_rf_pend !== 32'h0) begin errors++;
      $display("FAIL rstmid_d3: got occ=%0d ready=%0b ld=%0b pend=%h want 0 1 0 0",
               d3_occ, d3_ready, d3_out_ld, d3_rf_pend); end
    drive(WB_INSTR_OTHER, 32'h800, 1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{fp: 1'b0, addr: 5'd12, data: 64'hC0DE, pc: 32'h800});
    tick();
    idle();
    #1;
    e = sb.pop_front();
    checks++; if (d2_done !== 1'b1 || d2_rf_we !== 1'b1 || d2_rf_waddr !== e.addr ||
                  d2_rf_wdata !== e.data[31:0] || d2_pc !== e.pc) begin errors++;
      $display("FAIL rstmid_after: got done=%0b we=%0b a=%0d d=%h pc=%h want 1 1 a=%0d d=%h pc=%h",
               d2_done, d2_rf_we, d2_rf_waddr, d2_rf_wdata, d2_pc, e.addr, e.data[31:0], e.pc); end
    tick();
    checks++; if (d2_occ !== 2'd0 || sb.size() != 0) begin errors++;
      $display("FAIL sb_drain: got occ=%0d left=%0d want 0 0", d2_occ, sb.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_other_latency();
    test_load_order();
    test_back_to_back();
    test_load_error();
    test_fp_load();
    test_x0();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
